screen_state_controller: RTL and testbench

//  Game-phase sequencer for the Road Fighter screen. Owns the single source of truth for

---
 rtl/screen_state_controller.sv | 158 +++++++++++++++
 tb/tb_screen_state_controller.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/screen_state_controller.sv
// Game-phase sequencer for the Road Fighter screen: idle/play/win/lose requests plus the blinking cover mask.
// Optional build macro AUTO_RESTART_EN: the HOLD states return to IDLE by themselves after HOLD_FRAMES frames.
module screen_state_controller #(
  parameter int REVEAL_FRAMES = 15,
  parameter int BLINKS        = 3,
  parameter int HOLD_FRAMES   = 180
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       startKey,
  input  logic       winEvent,
  input  logic       loseEvent,
  output logic       gameReq,
  output logic       winReq,
  output logic       loseReq,
  output logic [3:0] coverMask,
  output logic [2:0] stateOut
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PLAY        = 3'd1,
    WIN_REVEAL  = 3'd2,
    WIN_HOLD    = 3'd3,
    LOSE_REVEAL = 3'd4,
    LOSE_HOLD   = 3'd5
  } state_t;

`ifdef AUTO_RESTART_EN
  localparam int FCNT_MAX = ((HOLD_FRAMES > REVEAL_FRAMES) ? HOLD_FRAMES : REVEAL_FRAMES) - 1;
`else
  localparam int FCNT_MAX = REVEAL_FRAMES - 1;
`endif
  localparam int FW      = (FCNT_MAX < 1) ? 1 : $clog2(FCNT_MAX + 1);
  localparam int TOGGLES = 2 * BLINKS - 1;
  localparam int TW      = $clog2(TOGGLES + 1);
  localparam logic [FW-1:0] REV_LAST = FW'(REVEAL_FRAMES - 1);
  localparam logic [TW-1:0] TOG_LAST = TW'(TOGGLES - 1);
`ifdef AUTO_RESTART_EN
  localparam logic [FW-1:0] HOLD_LAST = FW'(HOLD_FRAMES - 1);
`endif

  if (REVEAL_FRAMES < 1 || BLINKS < 1 || HOLD_FRAMES < 1) begin : g_bad_params
    $error("screen_state_controller: REVEAL_FRAMES, BLINKS and HOLD_FRAMES must all be >= 1");
  end

  state_t          state_q, state_d;
  logic            game_q, game_d, win_q, win_d, lose_q, lose_d;
  logic [3:0]      mask_q, mask_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic [TW-1:0]   tog_q, tog_d;
  logic            key_dly_q, key_dly_d;
  logic            key_rise;
  logic            go_idle;
  logic [3:0]      tgt;

  assign key_rise = startKey & ~key_dly_q;

  always_comb begin
    state_d   = state_q;
    game_d    = game_q;
    win_d     = win_q;
    lose_d    = lose_q;
    mask_d    = mask_q;
    frame_d   = frame_q;
    tog_d     = tog_q;
    key_dly_d = startKey;
    go_idle   = 1'b0;
    tgt       = (state_q == WIN_REVEAL) ? 4'b0010 : 4'b0100;
    case (state_q)
      IDLE: begin
        if (key_rise) begin
          state_d = PLAY;
          game_d  = 1'b1;
          mask_d  = 4'b0000;
        end
      end
      PLAY: begin
        // A crash in the same cycle as the finish line counts as a loss.
        if (loseEvent || winEvent) begin
          state_d = loseEvent ? LOSE_REVEAL : WIN_REVEAL;
          game_d  = 1'b0;
          lose_d  = loseEvent;
          win_d   = ~loseEvent;
          mask_d  = 4'b1111;
          frame_d = '0;
          tog_d   = '0;
        end
      end
      WIN_REVEAL, LOSE_REVEAL: begin
        if (startOfFrame) begin
          if (frame_q == REV_LAST) begin
            frame_d = '0;
            mask_d  = mask_q ^ tgt;
            tog_d   = tog_q + 1'b1;
            // The toggle count is odd, so the last toggle leaves the panel open.
            if (tog_q == TOG_LAST)
              state_d = (state_q == WIN_REVEAL) ? WIN_HOLD : LOSE_HOLD;
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
      end
      WIN_HOLD, LOSE_HOLD: begin
        if (key_rise) begin
          go_idle = 1'b1;
        end
`ifdef AUTO_RESTART_EN
        else if (startOfFrame) begin
          if (frame_q == HOLD_LAST) go_idle = 1'b1;
          else                      frame_d = frame_q + 1'b1;
        end
`endif
      end
      default: go_idle = 1'b1;
    endcase
    if (go_idle) begin
      state_d = IDLE;
      game_d  = 1'b0;
      win_d   = 1'b0;
      lose_d  = 1'b0;
      mask_d  = 4'b0111;
      frame_d = '0;
      tog_d   = '0;
    end
  end

  // A key already held when reset releases must not count as a press.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      game_q    <= 1'b0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
      mask_q    <= 4'b0111;
      frame_q   <= '0;
      tog_q     <= '0;
      key_dly_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      game_q    <= game_d;
      win_q     <= win_d;
      lose_q    <= lose_d;
      mask_q    <= mask_d;
      frame_q   <= frame_d;
      tog_q     <= tog_d;
      key_dly_q <= key_dly_d;
    end
  end

  assign gameReq   = game_q;
  assign winReq    = win_q;
  assign loseReq   = lose_q;
  assign coverMask = mask_q;
  assign stateOut  = state_q;

endmodule

// File: tb/tb_screen_state_controller.sv
// Scoreboard bench for screen_state_controller with REVEAL_FRAMES=2, BLINKS=2, HOLD_FRAMES=4.
module tb_screen_state_controller;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0, startKey = 1'b0, winEvent = 1'b0, loseEvent = 1'b0;
  logic       gameReq, winReq, loseReq;
  logic [3:0] coverMask;
  logic [2:0] stateOut;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } exp_t;
  exp_t sbq[$];

  // Packed expectation: {stateOut, gameReq, winReq, loseReq, coverMask}
  localparam logic [9:0] E_IDLE = {3'd0, 3'b000, 4'b0111};
  localparam logic [9:0] E_PLAY = {3'd1, 3'b100, 4'b0000};
  localparam logic [9:0] E_WR_C = {3'd2, 3'b010, 4'b1111};
  localparam logic [9:0] E_WR_O = {3'd2, 3'b010, 4'b1101};
  localparam logic [9:0] E_WH   = {3'd3, 3'b010, 4'b1101};
  localparam logic [9:0] E_LR_C = {3'd4, 3'b001, 4'b1111};
  localparam logic [9:0] E_LR_O = {3'd4, 3'b001, 4'b1011};
  localparam logic [9:0] E_LH   = {3'd5, 3'b001, 4'b1011};

  screen_state_controller #(
    .REVEAL_FRAMES(2),
    .BLINKS       (2),
    .HOLD_FRAMES  (4)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .startOfFrame(startOfFrame),
    .startKey    (startKey),
    .winEvent    (winEvent),
    .loseEvent   (loseEvent),
    .gameReq     (gameReq),
    .winReq      (winReq),
    .loseReq     (loseReq),
    .coverMask   (coverMask),
    .stateOut    (stateOut)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] observed();
    return {stateOut, gameReq, winReq, loseReq, coverMask};
  endfunction

  task automatic check_val(input string tag, input logic [9:0] got, input logic [9:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got st=%0d reqs=%b mask=%b, want st=%0d reqs=%b mask=%b",
               tag, got[9:7], got[6:4], got[3:0], exp[9:7], exp[6:4], exp[3:0]);
    end
  endtask

  // Drive one cycle of inputs, queue the output expected after the next edge, then score it.
  task automatic step(input string tag, input bit key, input bit win, input bit lose,
                      input bit sof, input logic [9:0] exp);
    exp_t e;
    startKey     = key;
    winEvent     = win;
    loseEvent    = lose;
    startOfFrame = sof;
    e.tag = tag;
    e.exp = exp;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check_val(e.tag, observed(), e.exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    startKey = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_state", observed(), E_IDLE);
    resetN = 1'b1;

    // Key held high across reset release is not a press; events ignored in IDLE
    step("held_key0", 1, 0, 0, 0, E_IDLE);
    step("held_key1", 1, 1, 1, 1, E_IDLE);
    step("key_low",   0, 0, 0, 0, E_IDLE);
    step("key_rise",  1, 0, 0, 0, E_PLAY);
    step("play_sof",  1, 0, 0, 1, E_PLAY);
    step("play_keyrelease", 0, 0, 0, 0, E_PLAY);

    // Win reveal: blink bit 1, ends open in WIN_HOLD after 6 frames
    step("win_evt",   0, 1, 0, 0, E_WR_C);
    step("win_f1",    0, 0, 0, 1, E_WR_C);
    step("win_f2",    0, 0, 0, 1, E_WR_O);
    step("win_nosof", 0, 0, 1, 0, E_WR_O);
    step("win_keyrise_ign", 1, 0, 0, 0, E_WR_O);
    step("win_f3",    1, 0, 0, 1, E_WR_O);
    step("win_f4",    0, 0, 0, 1, E_WR_C);
    step("win_f5",    0, 0, 0, 1, E_WR_C);
    step("win_f6",    0, 0, 0, 1, E_WH);
    step("win_hold",  0, 0, 1, 1, E_WH);
    step("win_hold_key", 1, 0, 0, 0, E_IDLE);

    // Simultaneous win and lose resolves to lose, blink on bit 2
    step("idle2",     0, 0, 0, 0, E_IDLE);
    step("key_rise2", 1, 0, 0, 0, E_PLAY);
    step("both_evt",  1, 1, 1, 0, E_LR_C);
    step("lose_f1",   0, 0, 0, 1, E_LR_C);
    step("lose_f2",   0, 0, 0, 1, E_LR_O);
    step("lose_f3",   0, 1, 0, 1, E_LR_O);
    step("lose_f4",   0, 0, 0, 1, E_LR_C);
    step("lose_f5",   0, 0, 0, 1, E_LR_C);
    step("lose_f6",   0, 0, 0, 1, E_LH);

`ifdef AUTO_RESTART_EN
    step("auto_h1", 0, 0, 0, 1, E_LH);
    step("auto_h2", 0, 0, 0, 1, E_LH);
    step("auto_h3", 0, 0, 0, 1, E_LH);
    step("auto_h4", 0, 0, 0, 1, E_IDLE);
`else
    for (int i = 0; i < 100; i++) step($sformatf("hold_f%0d", i), 0, 0, 0, 1, E_LH);
    step("lose_hold_key", 1, 0, 0, 0, E_IDLE);
`endif

    // Asynchronous reset in the middle of a reveal
    step("idle3",     0, 0, 0, 0, E_IDLE);
    step("key_rise3", 1, 0, 0, 0, E_PLAY);
    step("lose_evt3", 1, 0, 1, 0, E_LR_C);
    step("lose3_f1",  1, 0, 0, 1, E_LR_C);
    step("lose3_f2",  1, 0, 0, 1, E_LR_O);
    resetN = 1'b0;
    #1;
    check_val("async_reset", observed(), E_IDLE);
    @(posedge clk);
    #1;
    check_val("reset_hold", observed(), E_IDLE);
    resetN = 1'b1;
    step("post_reset_held", 1, 0, 0, 1, E_IDLE);
    step("post_reset_low",  0, 0, 0, 0, E_IDLE);
    step("post_reset_rise", 1, 0, 0, 0, E_PLAY);

    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d left, want 0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
